// File: rtl/sargantana_itag_memory_param.sv
// Parametrised N-way icache tag array: per-line valid bits, registered tag compare,
// and a sequenced valid sweep after reset or flush.
module sargantana_itag_memory_param #(
    parameter int unsigned N_WAY = 4,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned TAG_W = 27,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_WAY-1:0]       req_i,
    input  logic                   we_i,
    input  logic                   vbit_i,
    input  logic                   flush_i,
    input  logic                   inv_i,
    input  logic [TAG_W-1:0]       data_i,
    input  logic [IDX_W-1:0]       addr_i,
    input  logic [TAG_W-1:0]       cmp_tag_i,
    output logic                   ready_o,
    output logic                   rvalid_o,
    output logic [N_WAY*TAG_W-1:0] tag_way_o,
    output logic [N_WAY-1:0]       vbit_o,
    output logic [N_WAY-1:0]       hit_way_o,
    output logic                   hit_o,
    output logic                   multihit_o
);

    typedef enum logic [0:0] {StFlush, StIdle} state_e;

    state_e                   state_q;
    logic [IDX_W-1:0]         flush_cnt_q;
    logic                     ready_q;
    logic                     rvalid_q;
    logic [N_WAY*TAG_W-1:0]   tag_way_q;
    logic [N_WAY-1:0]         vbit_q;
    logic [N_WAY-1:0]         rd_req_q;
    logic [TAG_W-1:0]         cmp_tag_q;

    logic [TAG_W-1:0]         tag_mem   [N_WAY][DEPTH];
    logic                     valid_mem [N_WAY][DEPTH];

    logic sweep_act, inv_act, wr_act, rd_act;

    // One action per cycle in IDLE: flush > invalidate > write > read.
    always_comb begin
        sweep_act = !rst_i && (state_q == StFlush);
        inv_act   = !rst_i && (state_q == StIdle) && !flush_i && inv_i;
        wr_act    = !rst_i && (state_q == StIdle) && !flush_i && !inv_i && (|req_i) && we_i;
        rd_act    = !rst_i && (state_q == StIdle) && !flush_i && !inv_i && (|req_i) && !we_i;
    end

    // Storage has no reset; valids are cleared by the sweep one index per cycle.
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < N_WAY; w++) begin
            if (sweep_act) begin
                valid_mem[w][flush_cnt_q] <= 1'b0;
            end else if (inv_act) begin
                valid_mem[w][addr_i] <= 1'b0;
            end else if (wr_act && req_i[w]) begin
                tag_mem[w][addr_i]   <= data_i;
                valid_mem[w][addr_i] <= vbit_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StFlush;
            flush_cnt_q <= '0;
            ready_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            tag_way_q   <= '0;
            vbit_q      <= '0;
            rd_req_q    <= '0;
            cmp_tag_q   <= '0;
        end else begin
            rvalid_q <= 1'b0;
            unique case (state_q)
                StFlush: begin
                    vbit_q <= '0;
                    if (flush_i) begin
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                        if (flush_cnt_q == IDX_W'(DEPTH - 1)) begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                        end
                    end
                end
                StIdle: begin
                    if (flush_i) begin
                        state_q     <= StFlush;
                        ready_q     <= 1'b0;
                        flush_cnt_q <= '0;
                        vbit_q      <= '0;
                    end else if (rd_act) begin
                        rvalid_q  <= 1'b1;
                        rd_req_q  <= req_i;
                        cmp_tag_q <= cmp_tag_i;
                        for (int w = 0; w < N_WAY; w++) begin
                            if (req_i[w]) begin
                                tag_way_q[w*TAG_W +: TAG_W] <= tag_mem[w][addr_i];
                                vbit_q[w]                   <= valid_mem[w][addr_i];
                            end
                        end
                    end
                end
                default: state_q <= StFlush;
            endcase
        end
    end

    always_comb begin
        hit_way_o = '0;
        for (int w = 0; w < N_WAY; w++) begin
            hit_way_o[w] = rvalid_q & vbit_q[w] & rd_req_q[w] &
                           (tag_way_q[w*TAG_W +: TAG_W] == cmp_tag_q);
        end
    end

    assign hit_o      = |hit_way_o;
    // x & (x - 1) is non-zero exactly when more than one bit is set.
    assign multihit_o = |(hit_way_o & (hit_way_o - N_WAY'(1)));

    assign ready_o   = ready_q;
    assign rvalid_o  = rvalid_q;
    assign tag_way_o = tag_way_q;
    assign vbit_o    = vbit_q;

endmodule
